// File: rtl/sccb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sccb_write_scheduler
// Description : Round-robin scheduler that shares one SCCB write engine
//               between the boot sequencer (port 0) and runtime tuning
//               (port 1), with NACK retry, watchdog and post-write settle.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_write_scheduler #(
    parameter int         GAP_CYC          = 100,
    parameter int         RESET_SETTLE_CYC = 100000,
    parameter int         TIMEOUT_CYC      = 100000,
    parameter int         MAX_RETRY        = 2,
    parameter logic [7:0] COM7_ADDR        = 8'h12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_wr0,
    input  logic [15:0] req_wr1,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        eng_start,
    output logic [7:0]  eng_addr,
    output logic [7:0]  eng_data,
    output logic        eng_abort,
    input  logic        eng_done,
    input  logic        eng_nack,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam logic [19:0] c_gap_last     = 20'(GAP_CYC - 1);
    localparam logic [19:0] c_settle_last  = 20'(RESET_SETTLE_CYC - 1);
    localparam logic [19:0] c_timeout_last = 20'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  c_max_retry    = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_SETTLE  = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [19:0] r_cnt,        w_cnt_nxt;
    logic [2:0]  r_retry,      w_retry_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic        r_grant,      w_grant_nxt;
    logic [7:0]  r_addr,       w_addr_nxt;
    logic [7:0]  r_data,       w_data_nxt;
    logic        r_fail,       w_fail_nxt;
    logic        r_timeout,    w_timeout_nxt;
    logic [7:0]  r_err_count,  w_err_count_nxt;
    logic [1:0]  r_req_seen;

    logic [1:0]  w_cand;
    logic        w_pick;
    logic [15:0] w_word;
    logic [19:0] w_settle_last;

    logic [1:0]  w_req_ready;
    logic [1:0]  w_rsp_valid;
    logic        w_rsp_err;
    logic        w_rsp_timeout;
    logic        w_eng_start;
    logic        w_eng_abort;

    // A request is eligible only once it has been seen for a full cycle, so a
    // valid that drops before the accept cycle is never latched.
    assign w_cand = r_req_seen & req_valid;
    assign w_pick = (w_cand == 2'b11) ? ~r_last_grant : w_cand[1];
    assign w_word = w_pick ? req_wr1 : req_wr0;

    // Only a successful COM7 soft reset earns the long settle window.
    assign w_settle_last = (!r_fail && (r_addr == COM7_ADDR) && r_data[7])
                         ? c_settle_last : c_gap_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_count  <= '0;
            r_req_seen   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_fail       <= w_fail_nxt;
            r_timeout    <= w_timeout_nxt;
            r_err_count  <= w_err_count_nxt;
            r_req_seen   <= req_valid;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_retry_nxt      = r_retry;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_fail_nxt       = r_fail;
        w_timeout_nxt    = r_timeout;
        w_err_count_nxt  = r_err_count;
        w_req_ready      = 2'b00;
        w_rsp_valid      = 2'b00;
        w_rsp_err        = 1'b0;
        w_rsp_timeout    = 1'b0;
        w_eng_start      = 1'b0;
        w_eng_abort      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|w_cand) begin
                    w_req_ready      = w_pick ? 2'b10 : 2'b01;
                    w_addr_nxt       = w_word[15:8];
                    w_data_nxt       = w_word[7:0];
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_retry_nxt      = '0;
                    w_state_nxt      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_eng_start = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                w_cnt_nxt = r_cnt + 20'd1;
                // eng_done takes priority over a coincident watchdog expiry.
                if (eng_done) begin
                    if (!eng_nack) begin
                        w_fail_nxt    = 1'b0;
                        w_timeout_nxt = 1'b0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_SETTLE;
                    end else if (r_retry < c_max_retry) begin
                        w_retry_nxt = r_retry + 3'd1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_fail_nxt    = 1'b1;
                        w_timeout_nxt = 1'b0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_SETTLE;
                    end
                end else if (r_cnt == c_timeout_last) begin
                    w_eng_abort   = 1'b1;
                    w_fail_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (r_cnt == w_settle_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESPOND;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end

            S_RESPOND: begin
                w_rsp_valid   = r_grant ? 2'b10 : 2'b01;
                w_rsp_err     = r_fail;
                w_rsp_timeout = r_timeout;
                if (r_fail && (r_err_count != 8'hFF)) begin
                    w_err_count_nxt = r_err_count + 8'd1;
                end
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_err     = w_rsp_err;
    assign rsp_timeout = w_rsp_timeout;
    assign eng_start   = w_eng_start;
    assign eng_abort   = w_eng_abort;
    assign eng_addr    = r_addr;
    assign eng_data    = r_data;
    assign busy        = (r_state != S_IDLE);
    assign err_count   = r_err_count;

endmodule
`default_nettype wire
